// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Purpose  : Shared constants, register map and state type for the
//            rectangle-fill framebuffer writer.
// Contents : display geometry, framebuffer address width, register offsets,
//            CTRL/STATUS bit positions, fill FSM state enum and the
//            column-base helper.
// Revision : 1.0 - initial release
// ============================================================================
package fb_pkg;

  localparam int H_ACTIVE = 640;  // visible columns
  localparam int V_ACTIVE = 480;  // visible rows, also the column stride
  localparam int ADDR_W   = 19;   // framebuffer address width

  localparam logic [3:0] REG_X_LO   = 4'd0;
  localparam logic [3:0] REG_X_HI   = 4'd1;
  localparam logic [3:0] REG_Y_LO   = 4'd2;
  localparam logic [3:0] REG_Y_HI   = 4'd3;
  localparam logic [3:0] REG_W_LO   = 4'd4;
  localparam logic [3:0] REG_W_HI   = 4'd5;
  localparam logic [3:0] REG_H_LO   = 4'd6;
  localparam logic [3:0] REG_H_HI   = 4'd7;
  localparam logic [3:0] REG_COLOR  = 4'd8;
  localparam logic [3:0] REG_CTRL   = 4'd9;
  localparam logic [3:0] REG_STATUS = 4'd9;   // read view of the CTRL offset

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  // Start address of column x: x*480 built from two shifts (512x - 32x).
  function automatic logic [ADDR_W-1:0] col_base_of(input logic [9:0] x);
    logic [ADDR_W-1:0] xw;
    xw = ADDR_W'(x);
    return (xw << 9) - (xw << 5);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : fb_addr_gen
// Purpose  : Column-major pixel walker. Holds the row/column counters and
//            the column-base accumulator and presents a registered address.
// Ports    : clk, reset_n      - clock, async active-low reset
//            load             - start a new walk at (x_start, y_start)
//            advance          - current pixel accepted, step to the next one
//            x_start, y_start - first column / row of the clipped rectangle
//            x_end, y_end     - exclusive clipped bounds
//            addr             - current pixel address (registered)
//            last             - current pixel is the final one of the walk
// Revision : 1.0 - initial release
// ============================================================================
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              advance,
  input  logic [9:0]        x_start,
  input  logic [8:0]        y_start,
  input  logic [10:0]       x_end,
  input  logic [10:0]       y_end,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] C_STRIDE = ADDR_W'(V_ACTIVE);

  logic [8:0]        row_q, row_d;
  logic [9:0]        col_q, col_d;
  logic [8:0]        y0_q, y0_d;
  logic [10:0]       xe_q, xe_d;
  logic [10:0]       ye_q, ye_d;
  logic [ADDR_W-1:0] col_base_q, col_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic row_last;
  logic col_last;
  logic [ADDR_W-1:0] next_base;
  logic [ADDR_W-1:0] load_base;

  // Bounds are exclusive and a non-empty walk always has bounds >= 1.
  assign row_last  = ({2'b00, row_q} == (ye_q - 11'd1));
  assign col_last  = ({1'b0, col_q} == (xe_q - 11'd1));
  assign next_base = col_base_q + C_STRIDE;
  assign load_base = col_base_of(x_start);

  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    y0_d       = y0_q;
    xe_d       = xe_q;
    ye_d       = ye_q;
    col_base_d = col_base_q;
    addr_d     = addr_q;
    if (load) begin
      row_d      = y_start;
      col_d      = x_start;
      y0_d       = y_start;
      xe_d       = x_end;
      ye_d       = y_end;
      col_base_d = load_base;
      addr_d     = load_base + ADDR_W'(y_start);
    end else if (advance) begin
      if (row_last) begin
        // Wrap to the top row of the next column.
        row_d      = y0_q;
        col_d      = col_q + 10'd1;
        col_base_d = next_base;
        addr_d     = next_base + ADDR_W'(y0_q);
      end else begin
        row_d  = row_q + 9'd1;
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q      <= '0;
      col_q      <= '0;
      y0_q       <= '0;
      xe_q       <= '0;
      ye_q       <= '0;
      col_base_q <= '0;
      addr_q     <= '0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      y0_q       <= y0_d;
      xe_q       <= xe_d;
      ye_q       <= ye_d;
      col_base_q <= col_base_d;
      addr_q     <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = row_last && col_last;

endmodule
`default_nettype wire

// File: rtl/fb_rect_fill.sv
`default_nettype none
// ============================================================================
// Module   : fb_rect_fill
// Purpose  : Avalon-MM slave that turns one rectangle-fill command into a
//            stream of single-pixel framebuffer writes, clipped to 640x480,
//            column-major (addr = y + x*480).
// Ports    : clk, reset_n        - clock, async active-low reset
//            chipselect/write/read/address/writedata/readdata
//                                - Avalon-MM register port, read latency 1
//            fb_addr/fb_data/fb_we/fb_ready
//                                - framebuffer write port with handshake
//            done_irq            - one-cycle pulse when a command finishes
// Revision : 1.0 - initial release
// ============================================================================
module fb_rect_fill
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [3:0]        address,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              fb_we,
  input  logic              fb_ready,
  output logic              done_irq
);

  localparam logic [10:0] C_H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] C_V_LIM = 11'(V_ACTIVE);

  // Shadow (host-visible) parameter set.
  logic [9:0] sx_q, sx_d, sw_q, sw_d;
  logic [8:0] sy_q, sy_d, sh_q, sh_d;
  logic [7:0] scolor_q, scolor_d;
  // Working copy captured by START.
  logic [9:0] wx_q, wx_d, ww_q, ww_d;
  logic [8:0] wy_q, wy_d, wh_q, wh_d;
  logic [7:0] wcolor_q, wcolor_d;

  fill_state_t state_q, state_d;
  logic       fb_we_q, fb_we_d;
  logic [7:0] fb_data_q, fb_data_d;
  logic       done_irq_q, done_irq_d;
  logic       done_sticky_q, done_sticky_d;
  logic [7:0] readdata_q, readdata_d;

  logic        wr_en, rd_en, start, abort, xfer, busy, empty;
  logic [10:0] x_sum, y_sum, x_end, y_end;
  logic        gen_load, gen_advance, gen_last;
  logic [7:0]  status;

  assign wr_en = chipselect && write;
  assign rd_en = chipselect && read;
  assign start = wr_en && (address == REG_CTRL) && writedata[CTRL_START];
  assign abort = wr_en && (address == REG_CTRL) && writedata[CTRL_ABORT];
  assign xfer  = fb_we_q && fb_ready;
  assign busy  = (state_q != IDLE);

  // 11-bit sums: x+w and y+h can never wrap.
  assign x_sum = {1'b0, wx_q} + {1'b0, ww_q};
  assign y_sum = {2'b00, wy_q} + {2'b00, wh_q};
  assign x_end = (x_sum > C_H_LIM) ? C_H_LIM : x_sum;
  assign y_end = (y_sum > C_V_LIM) ? C_V_LIM : y_sum;
  assign empty = (ww_q == 10'd0) || (wh_q == 9'd0) ||
                 ({1'b0, wx_q} >= C_H_LIM) || ({2'b00, wy_q} >= C_V_LIM);

  always_comb begin
    status              = '0;
    status[STATUS_BUSY] = busy;
    status[STATUS_DONE] = done_sticky_q;
  end

  always_comb begin
    sx_d          = sx_q;
    sy_d          = sy_q;
    sw_d          = sw_q;
    sh_d          = sh_q;
    scolor_d      = scolor_q;
    wx_d          = wx_q;
    wy_d          = wy_q;
    ww_d          = ww_q;
    wh_d          = wh_q;
    wcolor_d      = wcolor_q;
    state_d       = state_q;
    fb_we_d       = fb_we_q;
    fb_data_d     = fb_data_q;
    done_sticky_d = done_sticky_q;
    readdata_d    = readdata_q;
    gen_load      = 1'b0;
    gen_advance   = 1'b0;

    // Shadow registers accept writes in any state.
    if (wr_en) begin
      case (address)
        REG_X_LO:  sx_d     = {sx_q[9:8], writedata};
        REG_X_HI:  sx_d     = {writedata[1:0], sx_q[7:0]};
        REG_Y_LO:  sy_d     = {sy_q[8], writedata};
        REG_Y_HI:  sy_d     = {writedata[0], sy_q[7:0]};
        REG_W_LO:  sw_d     = {sw_q[9:8], writedata};
        REG_W_HI:  sw_d     = {writedata[1:0], sw_q[7:0]};
        REG_H_LO:  sh_d     = {sh_q[8], writedata};
        REG_H_HI:  sh_d     = {writedata[0], sh_q[7:0]};
        REG_COLOR: scolor_d = writedata;
        default:   ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          wx_d     = sx_q;
          wy_d     = sy_q;
          ww_d     = sw_q;
          wh_d     = sh_q;
          wcolor_d = scolor_q;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (empty) begin
          state_d = DONE;
        end else begin
          gen_load  = 1'b1;
          fb_we_d   = 1'b1;
          fb_data_d = wcolor_q;
          state_d   = RUN;
        end
      end
      RUN: begin
        // A transfer on the abort edge still completes; nothing follows it.
        if (abort) begin
          fb_we_d = 1'b0;
          state_d = DONE;
        end else if (xfer) begin
          if (gen_last) begin
            fb_we_d = 1'b0;
            state_d = DONE;
          end else begin
            gen_advance = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        fb_we_d = 1'b0;
      end
    endcase

    // A STATUS read clears the sticky flag unless a command finishes now.
    if (rd_en && (address == REG_STATUS)) begin
      done_sticky_d = 1'b0;
    end
    if (state_d == DONE) begin
      done_sticky_d = 1'b1;
    end

    if (rd_en) begin
      readdata_d = (address == REG_STATUS) ? status : 8'h00;
    end

    // Registered so done_irq is high exactly during the DONE cycle.
    done_irq_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sx_q          <= '0;
      sy_q          <= '0;
      sw_q          <= '0;
      sh_q          <= '0;
      scolor_q      <= '0;
      wx_q          <= '0;
      wy_q          <= '0;
      ww_q          <= '0;
      wh_q          <= '0;
      wcolor_q      <= '0;
      state_q       <= IDLE;
      fb_we_q       <= 1'b0;
      fb_data_q     <= '0;
      done_irq_q    <= 1'b0;
      done_sticky_q <= 1'b0;
      readdata_q    <= '0;
    end else begin
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      sw_q          <= sw_d;
      sh_q          <= sh_d;
      scolor_q      <= scolor_d;
      wx_q          <= wx_d;
      wy_q          <= wy_d;
      ww_q          <= ww_d;
      wh_q          <= wh_d;
      wcolor_q      <= wcolor_d;
      state_q       <= state_d;
      fb_we_q       <= fb_we_d;
      fb_data_q     <= fb_data_d;
      done_irq_q    <= done_irq_d;
      done_sticky_q <= done_sticky_d;
      readdata_q    <= readdata_d;
    end
  end

  fb_addr_gen u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (gen_load),
    .advance (gen_advance),
    .x_start (wx_q),
    .y_start (wy_q),
    .x_end   (x_end),
    .y_end   (y_end),
    .addr    (fb_addr),
    .last    (gen_last)
  );

  assign readdata = readdata_q;
  assign fb_data  = fb_data_q;
  assign fb_we    = fb_we_q;
  assign done_irq = done_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_rect_fill.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fb_rect_fill
// Purpose  : Self-checking bench for fb_rect_fill. A pixel-list model built
//            from nested loops over the clipped rectangle is compared with
//            the framebuffer port on every cycle; directed steps pin timing,
//            status, abort and reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_rect_fill;
  import fb_pkg::*;

  logic              clk        = 1'b0;
  logic              reset_n    = 1'b0;
  logic              chipselect = 1'b0;
  logic              write      = 1'b0;
  logic              read       = 1'b0;
  logic [3:0]        address    = '0;
  logic [7:0]        writedata  = '0;
  logic [7:0]        readdata;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_data;
  logic              fb_we;
  logic              fb_ready   = 1'b1;
  logic              done_irq;

  int checks = 0;
  int errors = 0;

  int unsigned       exp_q[$];
  logic [7:0]        exp_color = '0;
  int                xfers = 0;
  bit                chk_done = 1'b1;
  bit                mon_en = 1'b1;
  bit                rand_ready = 1'b0;
  bit                exp_done = 1'b0;
  bit                stalled = 1'b0;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [7:0]        st_data = '0;
  logic [7:0]        rd;

  fb_rect_fill dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .fb_ready   (fb_ready),
    .done_irq   (done_irq)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic avm_write(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic avm_read(input logic [3:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic set_rect(input int x, input int y, input int w, input int h, input logic [7:0] c);
    avm_write(REG_X_LO, 8'(x));
    avm_write(REG_X_HI, 8'(x >> 8));
    avm_write(REG_Y_LO, 8'(y));
    avm_write(REG_Y_HI, 8'(y >> 8));
    avm_write(REG_W_LO, 8'(w));
    avm_write(REG_W_HI, 8'(w >> 8));
    avm_write(REG_H_LO, 8'(h));
    avm_write(REG_H_HI, 8'(h >> 8));
    avm_write(REG_COLOR, c);
  endtask

  // Expected pixel list: every (col,row) inside the clipped rectangle,
  // columns outermost, addr = row + col*480.
  task automatic model_load(input int x, input int y, input int w, input int h, input logic [7:0] c);
    int xe, ye;
    exp_q.delete();
    xfers     = 0;
    exp_color = c;
    xe = (x + w < H_ACTIVE) ? x + w : H_ACTIVE;
    ye = (y + h < V_ACTIVE) ? y + h : V_ACTIVE;
    if (w != 0 && h != 0)
      for (int c2 = x; c2 < xe; c2++)
        for (int r = y; r < ye; r++)
          exp_q.push_back(int'(c2 * V_ACTIVE + r));
  endtask

  task automatic start_cmd();
    avm_write(REG_CTRL, 8'h01);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_irq) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) fb_ready = 1'($urandom_range(0, 1));
  end

  // Per-cycle comparison of the framebuffer port against the model.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (chk_done) chk("done_irq", 32'(done_irq), 32'(exp_done));
      exp_done = 1'b0;
      if (stalled && !fb_we) chk("we_dropped", 32'(fb_we), 32'd1);
      if (fb_we) begin
        if (stalled) begin
          chk("stall_addr", 32'(fb_addr), 32'(st_addr));
          chk("stall_data", 32'(fb_data), 32'(st_data));
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_we", 32'(fb_we), 32'd0);
        end else begin
          chk("fb_addr", 32'(fb_addr), exp_q[0]);
          chk("fb_data", 32'(fb_data), 32'(exp_color));
          if (fb_ready) begin
            void'(exp_q.pop_front());
            xfers++;
            if (exp_q.size() == 0) exp_done = 1'b1;
          end
        end
        stalled = !fb_ready;
        st_addr = fb_addr;
        st_data = fb_data;
      end else begin
        stalled = 1'b0;
      end
    end else begin
      stalled  = 1'b0;
      exp_done = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #35;
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_fb_data", 32'(fb_data), 32'd0);
    chk("rst_done_irq", 32'(done_irq), 32'd0);
    chk("rst_readdata", 32'(readdata), 32'd0);
    reset_n = 1'b1;
    avm_read(REG_STATUS, rd);
    chk("rst_status", 32'(rd), 32'd0);

    // 2x3 fill at the origin
    set_rect(0, 0, 2, 3, 8'hAA);
    model_load(0, 0, 2, 3, 8'hAA);
    chk("model_len_2x3", exp_q.size(), 32'd6);
    chk("model_addr3_2x3", exp_q[3], 32'd480);
    start_cmd();
    @(negedge clk);
    chk("setup_cycle_we", 32'(fb_we), 32'd0);
    @(negedge clk);
    chk("first_we", 32'(fb_we), 32'd1);
    chk("first_addr", 32'(fb_addr), 32'd0);
    chk("first_data", 32'(fb_data), 32'hAA);
    wait_done(50);
    chk("xfers_2x3", 32'(xfers), 32'd6);
    chk("left_2x3", exp_q.size(), 32'd0);

    // Corner clip
    set_rect(638, 478, 10, 10, 8'h5A);
    model_load(638, 478, 10, 10, 8'h5A);
    chk("model_len_clip", exp_q.size(), 32'd4);
    chk("model_first_clip", exp_q[0], 32'd306718);
    chk("model_last_clip", exp_q[3], 32'd307199);
    start_cmd();
    wait_done(50);
    chk("xfers_clip", 32'(xfers), 32'd4);

    // Degenerate commands: no writes, done two cycles after START
    chk_done = 1'b0;
    set_rect(0, 0, 0, 5, 8'h77);
    model_load(0, 0, 0, 5, 8'h77);
    start_cmd();
    @(negedge clk);
    chk("w0_done_n1", 32'(done_irq), 32'd0);
    @(negedge clk);
    chk("w0_done_n2", 32'(done_irq), 32'd1);
    avm_read(REG_STATUS, rd);
    chk("w0_status1", 32'(rd), 32'h02);
    avm_read(REG_STATUS, rd);
    chk("w0_status2", 32'(rd), 32'h00);
    set_rect(700, 0, 5, 5, 8'h77);
    model_load(700, 0, 5, 5, 8'h77);
    start_cmd();
    @(negedge clk);
    chk("x700_done_n1", 32'(done_irq), 32'd0);
    @(negedge clk);
    chk("x700_done_n2", 32'(done_irq), 32'd1);
    avm_read(REG_STATUS, rd);
    chk("x700_status1", 32'(rd), 32'h02);
    avm_read(REG_STATUS, rd);
    chk("x700_status2", 32'(rd), 32'h00);
    chk("x700_xfers", 32'(xfers), 32'd0);
    chk_done = 1'b1;

    // 5x5 with random backpressure
    set_rect(3, 7, 5, 5, 8'h3C);
    model_load(3, 7, 5, 5, 8'h3C);
    rand_ready = 1'b1;
    start_cmd();
    wait_done(400);
    rand_ready = 1'b0;
    fb_ready   = 1'b1;
    chk("xfers_5x5", 32'(xfers), 32'd25);
    chk("left_5x5", exp_q.size(), 32'd0);

    // START during RUN is ignored; shadow write while busy is kept
    set_rect(10, 20, 4, 8, 8'h55);
    model_load(10, 20, 4, 8, 8'h55);
    start_cmd();
    repeat (3) @(posedge clk);
    avm_write(REG_X_LO, 8'd100);
    start_cmd();
    wait_done(100);
    chk("xfers_busy_start", 32'(xfers), 32'd32);
    model_load(100, 20, 4, 8, 8'h55);
    start_cmd();
    wait_done(100);
    chk("xfers_shadow", 32'(xfers), 32'd32);

    // ABORT mid-fill: transfers at the edges after SETUP up to the abort edge
    chk_done = 1'b0;
    set_rect(0, 0, 10, 10, 8'h11);
    model_load(0, 0, 10, 10, 8'h11);
    start_cmd();
    repeat (5) @(posedge clk);
    avm_write(REG_CTRL, 8'h02);
    @(negedge clk);
    chk("abort_we", 32'(fb_we), 32'd0);
    chk("abort_done", 32'(done_irq), 32'd1);
    chk("abort_xfers", 32'(xfers), 32'd6);
    avm_read(REG_STATUS, rd);
    chk("abort_status", 32'(rd), 32'h02);
    exp_q.delete();
    chk_done = 1'b1;

    // Asynchronous reset mid-RUN
    set_rect(0, 0, 10, 10, 8'h22);
    model_load(0, 0, 10, 10, 8'h22);
    start_cmd();
    repeat (4) @(posedge clk);
    #3;
    chk("pre_rst_we", 32'(fb_we), 32'd1);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_rst_we", 32'(fb_we), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("post_rst_we", 32'(fb_we), 32'd0);
    chk("post_rst_addr", 32'(fb_addr), 32'd0);
    chk("post_rst_data", 32'(fb_data), 32'd0);
    chk("post_rst_done", 32'(done_irq), 32'd0);
    chk("post_rst_readdata", 32'(readdata), 32'd0);
    avm_read(REG_STATUS, rd);
    chk("post_rst_status", 32'(rd), 32'd0);
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
